// File: rtl/muldiv_pkg.sv
// Shared types and defaults for the HI/LO multiply/divide sequencer.
// The divider is only built when MULDIV_DIV_EN is defined.
package muldiv_pkg;

  localparam int DEF_WIDTH = 32;

  typedef enum logic [1:0] {
    MULTU = 2'b00,
    MULT  = 2'b01,
    DIVU  = 2'b10,
    DIV   = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

endpackage

// File: rtl/muldiv_if.sv
// Issue/result bundle between the execute stage and the mul/div sequencer.
// Optional divider selected by MULDIV_DIV_EN (see muldiv_seq).
interface muldiv_if import muldiv_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
);
  // start is a level request, consumed on the first edge with busy=0.
  // While busy, start or hilo_rd raises stall and the requester holds its
  // inputs. done pulses one cycle; hi/lo/fault are already updated then.
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             hilo_rd;
  logic             stall;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             fault;
  state_t           state;

  modport master (
    output start, op, a, b, hilo_rd,
    input  stall, busy, done, hi, lo, fault, state
  );

  modport slave (
    input  start, op, a, b, hilo_rd,
    output stall, busy, done, hi, lo, fault, state
  );

endinterface

// File: rtl/muldiv_core.sv
// Unsigned iterative datapath: one shift-add (multiply) or restoring
// subtract-shift (divide, only with MULDIV_DIV_EN) step per enable.
module muldiv_core import muldiv_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
`ifdef MULDIV_DIV_EN
  input  logic               div,
`endif
  input  logic [WIDTH-1:0]   opa,
  input  logic [WIDTH-1:0]   opb,
  output logic [2*WIDTH-1:0] acc
);

  logic [WIDTH-1:0]   m;
  logic [WIDTH:0]     msum;
  logic [2*WIDTH-1:0] acc_step;
`ifdef MULDIV_DIV_EN
  logic               div_q;
  logic [WIDTH:0]     shifted;
  logic [WIDTH:0]     diff;
`endif

  // Multiply: acc = {partial product, multiplier}; divide: acc = {rem, quotient}.
  always_comb begin
    msum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, m & {WIDTH{acc[0]}}};
    acc_step = {msum, acc[WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
    shifted  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    diff     = shifted - {1'b0, m};
    if (div_q) begin
      if (diff[WIDTH]) acc_step = {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      else             acc_step = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      m   <= '0;
`ifdef MULDIV_DIV_EN
      div_q <= 1'b0;
`endif
    end else if (load) begin
`ifdef MULDIV_DIV_EN
      div_q <= div;
      acc   <= {{WIDTH{1'b0}}, div ? opa : opb};
      m     <= div ? opb : opa;
`else
      acc   <= {{WIDTH{1'b0}}, opb};
      m     <= opa;
`endif
    end else if (step) begin
      acc <= acc_step;
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// MIPS HI/LO multiply/divide sequencer: FSM, step counter, sign fix-up,
// HI/LO registers and pipeline stall. Divider built only with MULDIV_DIV_EN.
module muldiv_seq import muldiv_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic    clk,
  input  logic    rst,
  muldiv_if.slave bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_t             state, state_n;
  op_t                op_in;
  logic [CW-1:0]      cnt;
  logic               is_div, is_signed, div_short, go, quick, sa, sb, neg_q;
  logic [WIDTH-1:0]   mag_a, mag_b, res_hi, res_lo;
  logic [2*WIDTH-1:0] acc, prod;
`ifdef MULDIV_DIV_EN
  logic               div_q, rneg_q;
`endif

  assign op_in     = op_t'(bus.op);
  assign is_div    = (op_in == DIVU) || (op_in == DIV);
  assign is_signed = (op_in == MULT) || (op_in == DIV);
  assign sa        = is_signed & bus.a[WIDTH-1];
  assign sb        = is_signed & bus.b[WIDTH-1];
  assign mag_a     = sa ? -bus.a : bus.a;
  assign mag_b     = sb ? -bus.b : bus.b;

  // Divides that finish on the accepting edge without entering RUN.
`ifdef MULDIV_DIV_EN
  assign div_short = (bus.b == '0);
`else
  assign div_short = 1'b1;
`endif

  always_comb begin
    state_n = state;
    go      = 1'b0;
    quick   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          if (is_div && div_short) begin
            quick = 1'b1;
          end else begin
            go      = 1'b1;
            state_n = RUN;
          end
        end
      end
      RUN:     if (cnt == CW'(WIDTH - 1)) state_n = FIX;
      FIX:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  assign bus.state = state;
  assign bus.busy  = (state != IDLE);
  assign bus.stall = bus.busy & (bus.start | bus.hilo_rd);

  muldiv_core #(.WIDTH(WIDTH)) u_core (
    .clk  (clk),
    .rst  (rst),
    .load (go),
    .step (state == RUN),
`ifdef MULDIV_DIV_EN
    .div  (is_div),
`endif
    .opa  (mag_a),
    .opb  (mag_b),
    .acc  (acc)
  );

  // Remainder follows the dividend's sign; quotient and product follow sign xor.
  always_comb begin
    prod   = neg_q ? -acc : acc;
    res_hi = prod[2*WIDTH-1:WIDTH];
    res_lo = prod[WIDTH-1:0];
`ifdef MULDIV_DIV_EN
    if (div_q) begin
      res_lo = neg_q  ? -acc[WIDTH-1:0]       : acc[WIDTH-1:0];
      res_hi = rneg_q ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      neg_q     <= 1'b0;
      bus.hi    <= '0;
      bus.lo    <= '0;
      bus.done  <= 1'b0;
      bus.fault <= 1'b0;
`ifdef MULDIV_DIV_EN
      div_q     <= 1'b0;
      rneg_q    <= 1'b0;
`endif
    end else begin
      bus.done <= 1'b0;
      if (go) begin
        cnt       <= '0;
        neg_q     <= sa ^ sb;
        bus.fault <= 1'b0;
`ifdef MULDIV_DIV_EN
        div_q     <= is_div;
        rneg_q    <= sa;
`endif
      end
      if (state == RUN) cnt <= cnt + CW'(1);
      if (quick) begin
        bus.fault <= 1'b1;
        bus.done  <= 1'b1;
`ifdef MULDIV_DIV_EN
        bus.hi    <= bus.a;
        bus.lo    <= '1;
`endif
      end
      if (state == FIX) begin
        bus.hi   <= res_hi;
        bus.lo   <= res_lo;
        bus.done <= 1'b1;
      end
    end
  end

endmodule
